// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch sequencer
// Purpose: word width, fetch FSM states, redirect source encoding, PC step
//          and a word-alignment helper used by fetch_ctrl and its arbiter.
package fetch_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t PC_STEP = word_t'(4);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_TRAP,
    SRC_BR,
    SRC_JMP
  } redirect_src_e;

  function automatic word_t word_align(input word_t addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory request/grant/response bus
// Purpose: groups the imem handshake between the fetch sequencer and memory.
// Signals: imem_req/imem_addr (fetch -> mem), imem_gnt (request accepted),
//          imem_rvalid/imem_rdata (response, earliest the cycle after gnt).
// Modports: master = fetch side, slave = memory side.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// rtl/fetch_ctrl_redirect_arb.sv - priority select of the fetch redirect target
// Purpose: picks trap > branch > jump, aligns the target and reports whether
//          the ID/EX stage must also be killed.
// Ports: trap_req, br_taken/br_target, jmp_valid/jmp_target in;
//        redirect, target, flush_id_ex, misalign out (all combinational).
// Option: FETCH_MISALIGN_TRAP_EN turns a misaligned branch/jump target into a
//         trap redirect with a misalign pulse; otherwise the low bits are dropped.
module fetch_ctrl_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter word_t TRAP_VECTOR = word_t'('h100)
) (
  input  logic  trap_req,
  input  logic  br_taken,
  input  word_t br_target,
  input  logic  jmp_valid,
  input  word_t jmp_target,
  output logic  redirect,
  output word_t target,
  output logic  flush_id_ex,
  output logic  misalign
);

  redirect_src_e src;
  word_t         raw_target;

  always_comb begin
    src         = SRC_SEQ;
    raw_target  = '0;
    flush_id_ex = 1'b0;
    if (trap_req) begin
      src         = SRC_TRAP;
      raw_target  = TRAP_VECTOR;
      flush_id_ex = 1'b1;
    end else if (br_taken) begin
      src         = SRC_BR;
      raw_target  = br_target;
      flush_id_ex = 1'b1;
    end else if (jmp_valid) begin
      src         = SRC_JMP;
      raw_target  = jmp_target;
    end
    redirect = (src != SRC_SEQ);
    misalign = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    // A bad branch/jump target becomes a trap; the trap vector itself is trusted.
    if (src != SRC_TRAP && raw_target[1:0] != 2'b00) begin
      misalign    = 1'b1;
      flush_id_ex = 1'b1;
      target      = word_align(TRAP_VECTOR);
    end else begin
      target = word_align(raw_target);
    end
`else
    target = word_align(raw_target);
`endif
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer for the 5-stage pipeline
// Purpose: owns the fetch PC, runs a single-outstanding req/gnt/rvalid fetch,
//          presents a registered bundle to IF/ID with a one-entry hold buffer
//          for decode stalls, and raises flush pulses on redirect.
// Ports: clk, rst_n (async, active-low); stall; trap_req, br_taken/br_target,
//        jmp_valid/jmp_target; imem (fetch_ctrl_if.master); if_valid/if_pc/
//        if_instr; flush_if_id, flush_id_ex, misalign.
// Option: FETCH_MISALIGN_TRAP_EN (see fetch_ctrl_redirect_arb).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t RESET_VECTOR = word_t'('h0),
  parameter word_t TRAP_VECTOR  = word_t'('h100)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         trap_req,
  input  logic         br_taken,
  input  word_t        br_target,
  input  logic         jmp_valid,
  input  word_t        jmp_target,
  fetch_ctrl_if.master imem,
  output logic         if_valid,
  output word_t        if_pc,
  output word_t        if_instr,
  output logic         flush_if_id,
  output logic         flush_id_ex,
  output logic         misalign
);

  fetch_state_e state_q, state_d;
  word_t        fetch_pc_q, fetch_pc_d;
  word_t        req_pc_q, req_pc_d;
  logic         if_valid_q, if_valid_d;
  word_t        if_pc_q, if_pc_d;
  word_t        if_instr_q, if_instr_d;
  logic         hold_valid_q, hold_valid_d;
  word_t        hold_pc_q, hold_pc_d;
  word_t        hold_instr_q, hold_instr_d;

  logic  arb_redirect;
  word_t arb_target;
  logic  arb_flush_id_ex;
  logic  arb_misalign;
  logic  redirect;
  logic  req_outstanding;

  fetch_ctrl_redirect_arb #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_arb (
    .trap_req    (trap_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .redirect    (arb_redirect),
    .target      (arb_target),
    .flush_id_ex (arb_flush_id_ex),
    .misalign    (arb_misalign)
  );

  // BOOT is the settle cycle after reset; redirects there are ignored.
  assign redirect    = arb_redirect && (state_q != BOOT);
  assign flush_if_id = redirect;
  assign flush_id_ex = redirect && arb_flush_id_ex;
  assign misalign    = redirect && arb_misalign;

  // A response is still owed if granted now, or waiting and not arriving now.
  assign req_outstanding = ((state_q == REQ) && imem.imem_gnt) ||
                           (((state_q == WAIT) || (state_q == DRAIN)) && !imem.imem_rvalid);

  assign imem.imem_req  = (state_q == REQ) && !hold_valid_q;
  assign imem.imem_addr = fetch_pc_q;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    // Decode takes the bundle whenever it is not stalled.
    if (!stall) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem.imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (!if_valid_q || !stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem.imem_rdata;
            state_d    = REQ;
          end else begin
            hold_valid_d = 1'b1;
            hold_pc_d    = req_pc_q;
            hold_instr_d = imem.imem_rdata;
            state_d      = HOLD;
          end
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (!stall) begin
          if_valid_d   = 1'b1;
          if_pc_d      = hold_pc_q;
          if_instr_d   = hold_instr_q;
          hold_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // Redirect wins over stall and over any response handling above.
    if (redirect) begin
      fetch_pc_d   = arb_target;
      if_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      state_d      = req_outstanding ? DRAIN : REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_VECTOR;
      req_pc_q     <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  stall;
  logic  trap_req;
  logic  br_taken;
  word_t br_target;
  logic  jmp_valid;
  word_t jmp_target;
  logic  if_valid;
  word_t if_pc;
  word_t if_instr;
  logic  flush_if_id;
  logic  flush_id_ex;
  logic  misalign;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .trap_req    (trap_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .imem        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t  sb_q[$];
  word_t fired_q[$];
  bit    sb_en = 0;
  bit    stale = 0;
  int    lat   = 1;

  // Memory model: one outstanding request, response `lat` cycles after gnt.
  bit          pend = 0;
  int          cnt  = 0;
  word_t       p_addr;
  int unsigned serial = 0;

  always begin
    @(negedge clk);
    if (rst_n && bus.imem_req && bus.imem_gnt) begin
      pend   = 1;
      p_addr = bus.imem_addr;
      cnt    = lat;
      stale  = 0;
      serial++;
      fired_q.push_back(bus.imem_addr);
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend            = 0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hC0DE_0000 + serial;
        if (sb_en && !stale) sb_q.push_back({p_addr, bus.imem_rdata});
      end
    end
  end

  // Scoreboard: each bundle taken by decode must match the next response.
  always @(negedge clk) begin
    if (sb_en && rst_n && if_valid && !stall && !flush_if_id) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: bundle pc %h instr %h with nothing expected", if_pc, if_instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic wait_fire;
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) ok = 1;
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL wait_fire: no granted request within 20 cycles");
  endtask

  task automatic do_reset;
    cyc;
    rst_n = 0; stall = 0; trap_req = 0; br_taken = 0; jmp_valid = 0;
    bus.imem_gnt = 0; stale = 1; sb_en = 0;
    sb_q.delete(); fired_q.delete();
    cyc;
    rst_n = 1;
  endtask

  task automatic drain(input string name);
    bus.imem_gnt = 0;
    repeat (8) cyc;
    chk(name, sb_q.size(), 0);
  endtask

  typedef struct {
    logic  trap;
    logic  br;
    word_t br_t;
    logic  jmp;
    word_t jmp_t;
    logic  fif;
    logic  fex;
    logic  mis;
    word_t addr;
  } vec_t;

  vec_t vecs[7];
  int   vcount;

  initial begin
    rst_n = 0; stall = 0; trap_req = 0; br_taken = 0; jmp_valid = 0;
    br_target = '0; jmp_target = '0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;

    vecs[0] = '{1, 1, 32'h40, 1, 32'h80, 1, 1, 0, 32'h100};
    vecs[1] = '{0, 1, 32'h40, 1, 32'h80, 1, 1, 0, 32'h40};
    vecs[2] = '{0, 0, 32'h0,  1, 32'h80, 1, 0, 0, 32'h80};
    vecs[3] = '{0, 1, 32'h44, 0, 32'h0,  1, 1, 0, 32'h44};
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[4] = '{0, 0, 32'h0,  1, 32'h42, 1, 1, 1, 32'h100};
    vecs[5] = '{0, 1, 32'h47, 0, 32'h0,  1, 1, 1, 32'h100};
    vecs[6] = '{0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 32'h100};
`else
    vecs[4] = '{0, 0, 32'h0,  1, 32'h42, 1, 0, 0, 32'h40};
    vecs[5] = '{0, 1, 32'h47, 0, 32'h0,  1, 1, 0, 32'h44};
    vecs[6] = '{0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 32'h44};
`endif

    // Reset state
    smp;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_flush_if_id", flush_if_id, 0);
    chk("rst_flush_id_ex", flush_id_ex, 0);
    chk("rst_misalign", misalign, 0);
    cyc;
    rst_n = 1;
    smp;
    chk("boot_no_req", bus.imem_req, 0);
    cyc;
    smp;
    chk("req_after_boot", bus.imem_req, 1);
    chk("req_addr_reset_vector", bus.imem_addr, 32'h0);

    // Redirect priority table, applied in REQ with gnt held low
    for (int i = 0; i < 7; i++) begin
      cyc;
      trap_req = vecs[i].trap; br_taken = vecs[i].br; br_target = vecs[i].br_t;
      jmp_valid = vecs[i].jmp; jmp_target = vecs[i].jmp_t;
      smp;
      chk($sformatf("tbl%0d_flush_if_id", i), flush_if_id, vecs[i].fif);
      chk($sformatf("tbl%0d_flush_id_ex", i), flush_id_ex, vecs[i].fex);
      chk($sformatf("tbl%0d_misalign", i), misalign, vecs[i].mis);
      cyc;
      trap_req = 0; br_taken = 0; jmp_valid = 0;
      smp;
      chk($sformatf("tbl%0d_imem_addr", i), bus.imem_addr, vecs[i].addr);
      chk($sformatf("tbl%0d_imem_req", i), bus.imem_req, 1);
    end

    // Sequential stream from reset: addresses 0,4,8 and a bundle every other cycle
    do_reset;
    bus.imem_gnt = 1; lat = 1; sb_en = 1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      smp;
      if (if_valid) vcount++;
      cyc;
    end
    chk("stream_valid_count", vcount, 5);
    drain("stream_sb_empty");
    chk("stream_addr0", fired_q[0], 32'h0);
    chk("stream_addr1", fired_q[1], 32'h4);
    chk("stream_addr2", fired_q[2], 32'h8);

    // Wraparound of the fetch PC
    do_reset;
    cyc;
    jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
    cyc;
    jmp_valid = 0; bus.imem_gnt = 1; lat = 1; sb_en = 1;
    repeat (6) cyc;
    drain("wrap_sb_empty");
    chk("wrap_addr0", fired_q[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", fired_q[1], 32'h0);

    // Stall with the second response landing in the hold buffer
    do_reset;
    bus.imem_gnt = 1; lat = 1; sb_en = 1;
    wait_fire;
    cyc;
    cyc;
    stall = 1;
    smp;
    chk("stall_valid", if_valid, 1);
    chk("stall_pc_t2", if_pc, 32'h0);
    cyc; smp;
    chk("stall_pc_t3", if_pc, 32'h0);
    cyc; smp;
    chk("stall_pc_t4", if_pc, 32'h0);
    chk("stall_no_req_t4", bus.imem_req, 0);
    cyc; smp;
    chk("stall_no_req_t5", bus.imem_req, 0);
    cyc;
    stall = 0;
    smp;
    chk("unstall_pc_t6", if_pc, 32'h0);
    cyc; smp;
    chk("unstall_valid_t7", if_valid, 1);
    chk("unstall_pc_t7", if_pc, 32'h4);
    chk("unstall_req_t7", bus.imem_req, 1);
    chk("unstall_addr_t7", bus.imem_addr, 32'h8);
    drain("stall_sb_empty");

    // Branch while a slow response is outstanding: DRAIN discards it
    do_reset;
    bus.imem_gnt = 1; lat = 3; sb_en = 1;
    wait_fire;
    cyc;
    br_taken = 1; br_target = 32'h40; stale = 1;
    smp;
    chk("br_flush_if_id", flush_if_id, 1);
    chk("br_flush_id_ex", flush_id_ex, 1);
    cyc;
    br_taken = 0;
    smp;
    chk("drain_no_req_t2", bus.imem_req, 0);
    cyc; smp;
    chk("drain_no_req_t3", bus.imem_req, 0);
    cyc; smp;
    chk("drain_valid_t4", if_valid, 0);
    chk("drain_req_t4", bus.imem_req, 1);
    chk("drain_addr_t4", bus.imem_addr, 32'h40);
    cyc;
    drain("br_sb_empty");
    chk("br_fired_target", fired_q[1], 32'h40);

    // Reset asserted during WAIT; the late response must be ignored
    do_reset;
    bus.imem_gnt = 1; lat = 3; sb_en = 1;
    wait_fire;
    cyc;
    rst_n = 0; stale = 1;
    smp;
    chk("midrst_req", bus.imem_req, 0);
    chk("midrst_valid", if_valid, 0);
    chk("midrst_flush", flush_if_id, 0);
    cyc;
    rst_n = 1;
    cyc; smp;
    chk("midrst_restart_addr", bus.imem_addr, 32'h0);
    cyc; smp;
    chk("midrst_stray_ignored", if_valid, 0);
    cyc;
    drain("midrst_sb_empty");
    chk("midrst_refetch", fired_q[fired_q.size()-1], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
